// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );
endinterface

// File: rtl/pipelined_adder.sv
// Add/subtract split into STAGES equal carry chunks, one chunk per pipeline stage,
// with a single global advance enable so the whole pipe shifts or holds together.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             st_vld [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic             st_c   [STAGES];
  logic             st_ovf;

  logic             nx_vld [STAGES];
  logic [WIDTH-1:0] nx_a   [STAGES];
  logic [WIDTH-1:0] nx_b   [STAGES];
  logic [WIDTH-1:0] nx_sum [STAGES];
  logic             nx_c   [STAGES];
  logic             nx_ovf;

  logic             src_vld;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_sum;
  logic             src_cin;
  logic [CHUNK:0]   chunk_add;
  logic             adv;

  assign adv          = !st_vld[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;

  // B is stored already inverted for subtract, so later stages need no knowledge of in_sub.
  always_comb begin
    nx_vld    = '{default: 1'b0};
    nx_a      = '{default: '0};
    nx_b      = '{default: '0};
    nx_sum    = '{default: '0};
    nx_c      = '{default: 1'b0};
    nx_ovf    = 1'b0;
    src_vld   = 1'b0;
    src_a     = '0;
    src_b     = '0;
    src_sum   = '0;
    src_cin   = 1'b0;
    chunk_add = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      if (s == 0) begin
        src_vld = bus.in_valid;
        src_a   = bus.in_a;
        src_b   = bus.in_sub ? ~bus.in_b : bus.in_b;
        src_sum = '0;
        src_cin = bus.in_sub;
      end else begin
        src_vld = st_vld[s-1];
        src_a   = st_a[s-1];
        src_b   = st_b[s-1];
        src_sum = st_sum[s-1];
        src_cin = st_c[s-1];
      end
      chunk_add = {1'b0, src_a[s*CHUNK +: CHUNK]} + {1'b0, src_b[s*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, src_cin};
      nx_vld[s] = src_vld;
      nx_a[s]   = src_a;
      nx_b[s]   = src_b;
      nx_sum[s] = src_sum;
      nx_sum[s][s*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
      nx_c[s]   = chunk_add[CHUNK];
      if (s == STAGES - 1) begin
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        nx_ovf = (src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ chunk_add[CHUNK-1]) ^ chunk_add[CHUNK];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= '{default: 1'b0};
      st_a   <= '{default: '0};
      st_b   <= '{default: '0};
      st_sum <= '{default: '0};
      st_c   <= '{default: 1'b0};
      st_ovf <= 1'b0;
    end else if (adv) begin
      st_vld <= nx_vld;
      st_a   <= nx_a;
      st_b   <= nx_b;
      st_sum <= nx_sum;
      st_c   <= nx_c;
      st_ovf <= nx_ovf;
    end
  end

  assign bus.out_valid = st_vld[STAGES-1];
  assign bus.out_sum   = st_sum[STAGES-1];
  assign bus.out_carry = st_c[STAGES-1];
  assign bus.out_ovf   = st_ovf;
  assign bus.out_zero  = st_vld[STAGES-1] && (st_sum[STAGES-1] == '0);
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vector table, stall/reset sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    res_t         r;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_c, hold_o, hold_z;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t   r;
    longint sa, sb, sr;
    logic [W:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r.sum = a - b;
      r.c   = (a >= b);
      sr    = sa - sb;
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      r.sum = full[W-1:0];
      r.c   = full[W];
      sr    = sa + sb;
    end
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.sum == '0);
    return r;
  endfunction

  // Scoreboard: every handshake-completed result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending <= 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", {31'd0, bus.out_valid}, 1);
        chk("hold_sum", bus.out_sum, hold_sum);
        chk("hold_flags", {29'd0, bus.out_carry, bus.out_ovf, bus.out_zero},
            {29'd0, hold_c, hold_o, hold_z});
      end
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !bus.out_valid || bus.out_ready});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {31'd0, bus.out_valid}, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("sum", bus.out_sum, e.sum);
          chk("carry", {31'd0, bus.out_carry}, {31'd0, e.c});
          chk("ovf", {31'd0, bus.out_ovf}, {31'd0, e.o});
          chk("zero", {31'd0, bus.out_zero}, {31'd0, e.z});
        end
      end
      hold_pending <= bus.out_valid && !bus.out_ready;
      hold_sum     <= bus.out_sum;
      hold_c       <= bus.out_carry;
      hold_o       <= bus.out_ovf;
      hold_z       <= bus.out_zero;
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input res_t e);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic measure_latency(input string nm);
    int n;
    bit seen;
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    if (!seen) n = -1;
    chk(nm, n, S);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk(nm, exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    bit   done;
    tbl[0]  = '{32'd4,         32'd6,         1'b0, '{32'd10,        1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{32'd2,         32'd5,         1'b0, '{32'd7,         1'b0, 1'b0, 1'b0}};
    tbl[2]  = '{32'd5,         32'd8,         1'b0, '{32'd13,        1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{32'd5,         32'd8,         1'b1, '{32'hFFFFFFFD,  1'b0, 1'b0, 1'b0}};
    tbl[4]  = '{32'd8,         32'd5,         1'b1, '{32'd3,         1'b1, 1'b0, 1'b0}};
    tbl[5]  = '{32'h0000FFFF,  32'd1,         1'b0, '{32'h00010000,  1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{32'hFFFFFFFF,  32'd1,         1'b0, '{32'h00000000,  1'b1, 1'b0, 1'b1}};
    tbl[7]  = '{32'h7FFFFFFF,  32'd1,         1'b0, '{32'h80000000,  1'b0, 1'b1, 1'b0}};
    tbl[8]  = '{32'h80000000,  32'd1,         1'b1, '{32'h7FFFFFFF,  1'b1, 1'b1, 1'b0}};
    tbl[9]  = '{32'd0,         32'd0,         1'b1, '{32'h00000000,  1'b1, 1'b0, 1'b1}};
    tbl[10] = '{32'h80000000,  32'h80000000,  1'b0, '{32'h00000000,  1'b1, 1'b1, 1'b1}};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_out_sum", bus.out_sum, 0);
    chk("rst_flags", {29'd0, bus.out_carry, bus.out_ovf, bus.out_zero}, 0);
    rst_n = 1'b1;

    // First op accepted on the first edge after release; check latency
    send(tbl[0].a, tbl[0].b, tbl[0].sub, tbl[0].r);
    measure_latency("latency_first");
    drain("drain_first", 10);

    // Table back-to-back: all results drain within S edges of the last accept
    for (int i = 0; i < 11; i++) send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].r);
    drain("drain_table_throughput", S);

    // Stall: out_ready low for 3 cycles while the first result is presented
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'd100, 32'd1, 1'b0, model(32'd100, 32'd1, 1'b0));
        send(32'd200, 32'd2, 1'b1, model(32'd200, 32'd2, 1'b1));
        send(32'hFFFFFFF0, 32'h20, 1'b0, model(32'hFFFFFFF0, 32'h20, 1'b0));
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("stall_seen_valid", {31'd0, seen}, 1);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_stall", 20);

    // Reset with two operations in flight
    send(32'd11, 32'd22, 1'b0, model(32'd11, 32'd22, 1'b0));
    send(32'd33, 32'd44, 1'b0, model(32'd33, 32'd44, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("midrst_out_sum", bus.out_sum, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, bus.out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send(32'd1, 32'd1, 1'b0, '{32'd2, 1'b0, 1'b0, 1'b0});
    measure_latency("latency_after_rst");
    drain("drain_after_rst", 10);

    // Random traffic with random backpressure and bubbles
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [W-1:0] a, b;
          logic         sub;
          a   = pick();
          b   = pick();
          sub = $urandom_range(0, 1);
          send(a, b, sub, model(a, b, sub));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_random", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, meaning pipeline depth and number of equal carry chunks; legal range is 1..4, and WIDTH SHALL be divisible by STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning an operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the operands this cycle.
REQ-007 The block SHALL have port in_a, input, WIDTH bits, meaning operand A.
REQ-008 The block SHALL have port in_b, input, WIDTH bits, meaning operand B.
REQ-009 The block SHALL have port in_sub, input, 1 bit: 0 computes A+B, 1 computes A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the sink consumes the result this cycle.
REQ-012 The block SHALL have port out_sum, output, WIDTH bits, meaning the result modulo 2^WIDTH.
REQ-013 The block SHALL have port out_carry, output, 1 bit, meaning the carry-out of the MSB; for subtract, 1 means no borrow.
REQ-014 The block SHALL have port out_ovf, output, 1 bit, meaning two's-complement signed overflow.
REQ-015 The block SHALL have port out_zero, output, 1 bit, meaning out_sum equals 0.

Function
REQ-016 Subtract SHALL be implemented as A + ~B + 1; add uses carry-in 0.
REQ-017 Stage k (0..STAGES-1) SHALL add chunk k (bits k*W/S .. (k+1)*W/S-1) using the registered carry from stage k-1; untouched upper operand chunks and finished lower sum chunks SHALL be carried forward in pipeline registers.
REQ-018 Each stage SHALL hold a valid bit; a transfer is in_valid && in_ready; a result leaves on out_valid && out_ready.
REQ-019 Global advance enable SHALL be adv = !out_valid || out_ready; when adv=1 every stage shifts one position, and when adv=0 all stage registers hold.
REQ-020 in_ready SHALL equal adv (combinational, no dependency on in_valid).
REQ-021 Latency SHALL be exactly STAGES cycles from accepting edge to out_valid under no stall; throughput SHALL be one result per cycle.
REQ-022 Bubbles (in_valid=0 while adv=1) SHALL propagate as invalid stages; invalid stages SHALL not assert out_valid.
REQ-023 While out_valid=1 and out_ready=0, out_sum/out_carry/out_ovf/out_zero SHALL remain stable.
REQ-024 out_ovf SHALL equal carry into MSB XOR carry out of MSB, computed in the final stage; out_zero SHALL be derived from the complete registered sum.
REQ-025 Operands accepted back-to-back SHALL not interact; results emerge in acceptance order.
REQ-026 With STAGES=1, the block SHALL be a single registered adder with the same handshake.

Reset
REQ-027 On rst_n=0, all stage valid bits SHALL clear immediately (asynchronously); out_valid=0, out_sum=0, out_carry=0, out_ovf=0, out_zero=0.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after release.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-030 The first accepting edge SHALL be the first rising clk edge with rst_n=1.

Verification (WIDTH=32, STAGES=2, out_ready=1 unless stated)
REQ-031 A=4, B=6, sub=0 -> two cycles later out_sum=10, carry=0, ovf=0, zero=0; then A=2, B=5 -> 7; A=5, B=8 -> 13, back-to-back, one per cycle.
REQ-032 A=5, B=8, sub=1 -> out_sum=0xFFFFFFFD, carry=0, ovf=0; A=8, B=5, sub=1 -> 3, carry=1.
REQ-033 A=0x0000FFFF, B=1 -> 0x00010000 (carry crosses chunk boundary); A=0xFFFFFFFF, B=1 -> sum=0, carry=1, zero=1; A=0x7FFFFFFF, B=1 -> 0x80000000, ovf=1.
REQ-034 Three back-to-back inputs, out_ready=0 for 3 cycles while the first is presented -> in_ready=0, output held stable; then out_ready=1 -> all three delivered in order, none lost or duplicated.
REQ-035 Two operations in flight, rst_n pulsed low mid-cycle -> out_valid drops at once, no result is delivered after release, and a new 1+1 yields 2 after two cycles.
